alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered 32-bit integer ALU for the pipelined CPU execute stage.
- Supports add, sub, or, and, signed/unsigned set-less-than, a not-equal compare for branches, a NOP code, and an upper-load path for `lui`.
- Operands and control are sampled on the clock edge; result and zero flag are registered with 1-cycle latency.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/control valid this cycle.
- inA  input  32  operand A (rs value).
- inB  input  32  operand B (rt value or extended immediate).
- ALUctrl  input  4  operation select.
- upperLoad  input  1  when 1, the result is inB shifted left by 16; ALUctrl is ignored.
- out_valid  output  1  result/zero hold a valid operation.
- result  output  32  registered ALU result.
- zero  output  1  registered flag, 1 when the registered result equals 0.
- overflow  output  1  present only with ALU_OVF_EN; see Optional Feature.

Behaviour:
- Reset: while rst_n is low, asynchronously force result=0, zero=1, out_valid=0 (and overflow=0). Reset takes priority over any clock edge. A reset mid-operation discards the in-flight result.
- Latency: if in_valid=1 at rising edge N, result/zero/out_valid reflect that operation after edge N. If in_valid=0 at an edge, out_valid goes to 0 and result/zero hold their previous values.
- Back-to-back issue every cycle is allowed. There is no stall or backpressure.
- Opcodes (ALUctrl), applied when upperLoad=0:
  - 0000 ADD: A+B mod 2^32.
  - 0001 SUB: A−B mod 2^32.
  - 0010 OR: A|B.
  - 0011 AND: A&B.
  - 0100 SLT: 1 if $signed(A) < $signed(B), else 0 (zero-extended to 32 bits).
  - 0101 SLTU: 1 if A < B unsigned, else 0.
  - 0110 BNE: 1 if A != B, else 0.
  - 1111 NOP: 0.
  - Any other code: 0.
- upperLoad=1: result = {inB[15:0], 16'h0}, regardless of ALUctrl.
- zero is always computed from the final next-state result (result==0). For BNE this gives zero=1 exactly when A==B.
- Computation is a single combinational block feeding one register stage. No multi-cycle operations.
- Boundary cases:
  - ADD/SUB wrap silently. Example: 0xFFFFFFFF + 1 = 0, zero=1.
  - SLT with A=0x80000000, B=0 gives 1. SLTU with the same operands gives 0.

Optional Feature:
- Macro ALU_OVF_EN.
- When defined: adds output port overflow (1 bit), registered alongside result.
  - For ADD: overflow=1 when both operands have the same sign and the sum's sign differs.
  - For SUB: overflow=1 when the operand signs differ and the difference's sign differs from A.
  - For all other ops, and when upperLoad=1: overflow=0.
  - Reset value 0. Holds its value when in_valid=0.
  - result still carries the wrapped value; overflow does not trap.
- When undefined: the overflow port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Assert rst_n=0 asynchronously between clock edges -> result=0, zero=1, out_valid=0 immediately. Release, then issue ADD 2+3 with in_valid=1 -> after the next edge result=5, zero=0, out_valid=1.
2. inA=0xFFFF0000, inB=0x7FFFFFFF, in_valid=1, one issue per cycle:
   - SLT -> result 1.
   - SLTU -> result 0, zero=1.
   - AND -> result 0x7FFF0000.
   - BNE -> result 1, zero=0.
   - Each value appears one cycle after its issue.
3. inA=inB=0x00000001, ALUctrl=BNE -> result 0, zero=1. Then SUB with the same operands -> result 0, zero=1.
4. upperLoad=1, inB=0x00001234, ALUctrl=SUB -> result 0x12340000. Also ALUctrl=NOP with upperLoad=0 -> result 0, zero=1. Undefined code 0111 -> result 0.
5. Issue ADD 1+1, then drop in_valid for two cycles -> result stays 2, out_valid=0. Assert rst_n low mid-sequence -> outputs return to reset values at once.
6. With ALU_OVF_EN:
   - ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1.
   - SUB 0x80000000−1 -> result 0x7FFFFFFF, overflow=1.
   - ADD 1+1 -> overflow=0.

Source files
------------

// File: rtl/alu_core.sv
// Registered 32-bit execute-stage ALU: one combinational op stage feeding a single result register.
// Optional signed-overflow output is enabled by defining ALU_OVF_EN.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       ALUctrl,
  input  logic             upperLoad,
`ifdef ALU_OVF_EN
  output logic             overflow,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;
  logic        [WIDTH-1:0] alu_res;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_comb begin
    a_s  = inA;
    b_s  = inB;
    sum  = a_s + b_s;
    diff = a_s - b_s;
    alu_res = '0;
    if (upperLoad) begin
      alu_res = inB << 16;
    end else begin
      case (ALUctrl)
        OP_ADD:  alu_res = sum;
        OP_SUB:  alu_res = diff;
        OP_OR:   alu_res = inA | inB;
        OP_AND:  alu_res = inA & inB;
        OP_SLT:  alu_res = WIDTH'(a_s < b_s);
        OP_SLTU: alu_res = WIDTH'(inA < inB);
        OP_BNE:  alu_res = WIDTH'(inA != inB);
        default: alu_res = '0;
      endcase
    end
  end

  // Register stage: idle cycles drop valid but keep the last result visible.
  always_comb begin
    valid_d  = in_valid;
    result_d = result_q;
    zero_d   = zero_q;
    if (in_valid) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

`ifdef ALU_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = 1'b0;
      if (!upperLoad && ALUctrl == OP_ADD) ovf_d = add_ovf(a_s, b_s, sum);
      if (!upperLoad && ALUctrl == OP_SUB) ovf_d = sub_ovf(a_s, b_s, diff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed vector table, hand-written reset/hold sequences, and random
// stimulus against an arithmetic reference model. Define ALU_OVF_EN to also cover overflow.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inA, inB;
  logic [3:0]  ALUctrl;
  logic        upperLoad;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_OVF_EN
  logic        overflow;
`endif

  int errors = 0;
  int checks = 0;

  alu_core #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .inA(inA),
    .inB(inB),
    .ALUctrl(ALUctrl),
    .upperLoad(upperLoad),
`ifdef ALU_OVF_EN
    .overflow(overflow),
`endif
    .out_valid(out_valid),
    .result(result),
    .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic        ul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic ul,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    ALUctrl   = op;
    upperLoad = ul;
    inA       = a;
    inB       = b;
  endtask

  // Reference model straight from the opcode table, using plain integer arithmetic.
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic ul,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ul) return 32'((b % 32'h10000) * 32'h10000);
    case (op)
      4'd0: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      4'd1: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'd2: return a | b;
      4'd3: return a & b;
      4'd4: return (sa < sb) ? 32'd1 : 32'd0;
      4'd5: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd6: return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic ul,
                                     input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ul) return 1'b0;
    if (op == 4'd0) r = sa + sb;
    else if (op == 4'd1) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] exp_res;
  logic        exp_z;
  logic        exp_v;
  logic        exp_ovf;
  logic [3:0]  op_r;
  logic        ul_r, v_r;
  logic [31:0] a_r, b_r;

  initial begin
    vecs.push_back('{4'h0, 1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0});
    vecs.push_back('{4'h4, 1'b0, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 1'b0, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h3, 1'b0, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h7FFF_0000, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 1'b0, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h1, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0});
    vecs.push_back('{4'hF, 1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h7, 1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h4, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h2, 1'b0, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b0});
    vecs.push_back('{4'h0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{4'h1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{4'h0, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0});
    vecs.push_back('{4'h1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0});

    // Asynchronous reset applied between clock edges.
    rst_n = 1'b1;
    drive(1'b1, 4'h0, 1'b0, 32'h0000_0009, 32'h0000_0009);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
`ifdef ALU_OVF_EN
    check("reset_ovf", 32'(overflow), 32'd0);
`endif
    step();
    check("reset_hold_result", result, 32'h0);
    #3;
    rst_n = 1'b1;

    // Directed table, issued back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].op, vecs[i].ul, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
`ifdef ALU_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
`endif
    end

    // Hold while idle, then reset mid-sequence.
    drive(1'b1, 4'h0, 1'b0, 32'h1, 32'h1);
    step();
    check("hold_issue_result", result, 32'h2);
    drive(1'b0, 4'h1, 1'b0, 32'h5, 32'h5);
    step();
    check("hold1_result", result, 32'h2);
    check("hold1_valid", 32'(out_valid), 32'd0);
    check("hold1_zero", 32'(zero), 32'd0);
    step();
    check("hold2_result", result, 32'h2);
    check("hold2_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 4'h0, 1'b0, 32'h7FFF_FFFF, 32'h1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_result", result, 32'h0);
    check("midreset_zero", 32'(zero), 32'd1);
    check("midreset_valid", 32'(out_valid), 32'd0);
`ifdef ALU_OVF_EN
    check("midreset_ovf", 32'(overflow), 32'd0);
`endif
    step();
    #3;
    rst_n = 1'b1;

    // Random stimulus against the reference model.
    exp_res = 32'h0;
    exp_z   = 1'b1;
    exp_ovf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v_r  = ($urandom_range(0, 3) != 0);
      ul_r = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: op_r = 4'($urandom_range(0, 6));
        1: op_r = 4'hF;
        default: op_r = 4'($urandom);
      endcase
      a_r = rand_operand();
      b_r = ($urandom_range(0, 4) == 0) ? a_r : rand_operand();
      drive(v_r, op_r, ul_r, a_r, b_r);
      exp_v = v_r;
      if (v_r) begin
        exp_res = model_res(op_r, ul_r, a_r, b_r);
        exp_z   = (exp_res == 32'h0);
        exp_ovf = model_ovf(op_r, ul_r, a_r, b_r);
      end
      step();
      check($sformatf("rnd%0d_result op=%0h ul=%0b", i, op_r, ul_r), result, exp_res);
      check($sformatf("rnd%0d_zero", i), 32'(zero), 32'(exp_z));
      check($sformatf("rnd%0d_valid", i), 32'(out_valid), 32'(exp_v));
`ifdef ALU_OVF_EN
      check($sformatf("rnd%0d_ovf", i), 32'(overflow), 32'(exp_ovf));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
